// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor slice reused over N cycles, LSB first,
// with the running borrow held in a flip-flop. diff/borrow update only on completion.
module serial_subtractor #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         bit_out,
    output logic [1:0]   state_dbg
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE; a and b are captured on that same edge.
    // start during RUN or DONE is dropped, not queued.
    state_t        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bflop_q, bflop_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          x, y, c, d, bo;
    logic [N-1:0]  res_shift;

    always_comb begin
        x  = a_sh_q[0];
        y  = b_sh_q[0];
        c  = bflop_q;
        d  = x ^ y ^ c;
        bo = (~x & y) | (~(x ^ y) & c);
        // New bit enters from the MSB side so the first computed bit ends up in bit 0.
        res_shift = (res_q >> 1) | (N'(d) << (N - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bflop_d  = bflop_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                bflop_d = bo;
                res_d   = res_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = res_shift;
                    borrow_d = bo;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bflop_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bflop_q  <= bflop_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign bit_out   = busy & d;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: N=4 vector table, held-start, mid-run reset,
// exhaustive N=4 sweep, and a short N=1 sequence on a second instance.
module tb_serial_subtractor;
    logic       clk, rst_n;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done, borrow, bit_out;
    logic [3:0] diff;
    logic [1:0] state_dbg;

    logic       start1;
    logic [0:0] a1, b1, diff1;
    logic       busy1, done1, borrow1, bit_out1;
    logic [1:0] state_dbg1;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow),
        .bit_out(bit_out), .state_dbg(state_dbg)
    );

    serial_subtractor #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1),
        .bit_out(bit_out1), .state_dbg(state_dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One N=4 operation: busy count, serial bits, final diff/borrow.
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] ed, input logic eb,
                         input string nm, input bit scramble);
        int nb;
        logic [3:0] bits;
        bit got;
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0;
        nb = 0; bits = '0; got = 1'b0;
        for (int cyc = 0; cyc < 12 && !got; cyc++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy && nb < 4) begin
                    bits[nb] = bit_out;
                    nb++;
                end
                if (scramble) begin
                    a = 4'($urandom_range(0, 15));
                    b = 4'($urandom_range(0, 15));
                end
                step();
            end
        end
        check({nm, "_done_seen"}, int'(got), 1);
        check({nm, "_busy_cycles"}, nb, 4);
        check({nm, "_diff"}, int'(diff), int'(ed));
        check({nm, "_borrow"}, int'(borrow), int'(eb));
        check({nm, "_bits"}, int'(bits), int'(ed));
        check({nm, "_busy_at_done"}, int'(busy), 0);
        check({nm, "_bit_out_at_done"}, int'(bit_out), 0);
        step();
        check({nm, "_done_pulse"}, int'(done), 0);
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic ed,
                          input logic eb, input string nm);
        a1 = av; b1 = bv; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check({nm, "_busy"}, int'(busy1), 1);
        check({nm, "_bit_out"}, int'(bit_out1), int'(ed));
        step();
        check({nm, "_done"}, int'(done1), 1);
        check({nm, "_diff"}, int'(diff1), int'(ed));
        check({nm, "_borrow"}, int'(borrow1), int'(eb));
        step();
        check({nm, "_idle"}, int'(done1 | busy1), 0);
    endtask

    initial begin
        int gap;
        bit got;
        vecs[0] = '{4'd3,  4'd1,  4'd2,  1'b0};
        vecs[1] = '{4'd1,  4'd2,  4'd15, 1'b1};
        vecs[2] = '{4'd2,  4'd2,  4'd0,  1'b0};
        vecs[3] = '{4'd0,  4'd15, 4'd1,  1'b1};
        vecs[4] = '{4'd9,  4'd4,  4'd5,  1'b0};
        vecs[5] = '{4'd4,  4'd9,  4'd11, 1'b1};
        vecs[6] = '{4'd15, 4'd0,  4'd15, 1'b0};
        vecs[7] = '{4'd8,  4'd8,  4'd0,  1'b0};
        vecs[8] = '{4'd0,  4'd1,  4'd15, 1'b1};
        vecs[9] = '{4'd15, 4'd15, 4'd0,  1'b0};

        start = 0; a = 0; b = 0; start1 = 0; a1 = 0; b1 = 0;
        rst_n = 1'b0;
        #23;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_borrow", int'(borrow), 0);
        check("reset_bit_out", int'(bit_out), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].av, vecs[i].bv, vecs[i].ed, vecs[i].eb, $sformatf("vec%0d", i), 1'b0);

        // operands changing every RUN cycle must not disturb the result
        do_op(4'd0, 4'd15, 4'd1, 1'b1, "isolate", 1'b1);
        repeat (3) step();
        check("hold_diff", int'(diff), 1);
        check("hold_borrow", int'(borrow), 1);

        // start held high: done period is N+2 and start in DONE is not taken
        a = 4'd9; b = 4'd4; start = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 12 && !got; cyc++) begin
            step();
            got = done;
        end
        check("held_first_done", int'(got), 1);
        check("held_first_diff", int'(diff), 5);
        check("held_first_borrow", int'(borrow), 0);
        a = 4'd4; b = 4'd9;
        gap = 0; got = 1'b0;
        for (int cyc = 0; cyc < 12 && !got; cyc++) begin
            step();
            gap++;
            got = done;
        end
        start = 1'b0;
        check("held_second_done", int'(got), 1);
        check("held_period", gap, 6);
        check("held_second_diff", int'(diff), 11);
        check("held_second_borrow", int'(borrow), 1);
        step();

        // asynchronous reset in RUN cycle 2
        a = 4'd5; b = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_busy", int'(busy), 0);
        check("midrun_done", int'(done), 0);
        check("midrun_diff", int'(diff), 0);
        check("midrun_borrow", int'(borrow), 0);
        check("midrun_bit_out", int'(bit_out), 0);
        #4 rst_n = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (done || busy) got = 1'b1;
        end
        check("post_reset_quiet", int'(got), 0);
        do_op(4'd7, 4'd7, 4'd0, 1'b0, "after_reset", 1'b0);

        // exhaustive sweep
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                do_op(4'(i), 4'(j), 4'((i - j) & 15), (i < j), $sformatf("ex_%0d_%0d", i, j), 1'b0);

        // N=1 instance: RUN is a single cycle
        do_op1(1'b0, 1'b1, 1'b1, 1'b1, "n1_0m1");
        do_op1(1'b1, 1'b0, 1'b1, 1'b0, "n1_1m0");
        do_op1(1'b1, 1'b1, 1'b0, 1'b0, "n1_1m1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = A − B (mod 2^N) plus a borrow flag, one bit per clock, LSB first.
- It is a full-subtractor slice reused over N cycles, with the borrow carried in a flip-flop.
- It is the inverse-direction counterpart to the team's combinational ripple adder.
- It sits between the switch bank (operands, start) and the LED bank (result, status).

Parameters:
- N, 2, operand and result width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; captured when start is accepted.
- b  input  N  subtrahend; captured when start is accepted.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse; high while the state is DONE.
- diff  output  N  registered result (a − b) mod 2^N; held until the next completion.
- borrow  output  1  registered final borrow; 1 iff a < b unsigned.
- bit_out  output  1  difference bit produced in the current RUN cycle; 0 outside RUN.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow=0, bit_out=0.
  - Internal shift registers, borrow flip-flop and bit counter cleared.
  - Reset mid-RUN aborts the operation. No done pulse is produced, and diff/borrow read 0 after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: load a_sh<=a, b_sh<=b, bflop<=0, cnt<=0; next state RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), per cycle with x=a_sh[0], y=b_sh[0], c=bflop:
  - d = x^y^c.
  - bo = (~x&y) | (~(x^y)&c).
  - bit_out = d (combinational from the registered state).
  - At the edge: d is shifted into the result shift register from the MSB side, so after N shifts bit 0 is the first computed bit.
  - a_sh and b_sh shift right; bflop<=bo; cnt<=cnt+1.
  - At the edge where cnt==N−1: diff<=final result register (including this cycle's d), borrow<=bo, next state DONE.
- DONE:
  - done=1, busy=0.
  - Next edge: IDLE unconditionally.
  - start during DONE is ignored, not queued.
- Latency: start accepted at edge k → busy high over edges k..k+N → diff/borrow updated and done high from edge k+N to k+N+1.
  - Total latency is N+1 cycles from the accepting edge to done deassertion.
  - Minimum issue interval is N+2 cycles; start held high continuously gives back-to-back operations at that period.
- Operand isolation: a/b changes after acceptance have no effect on the running operation.
- start while busy or done: ignored.
- N=1: RUN lasts exactly one cycle.
- Overflow/wrap: diff is always modulo 2^N. A borrow out of the MSB sets borrow and never widens diff.
- diff and borrow keep their last completed values through IDLE and RUN; they change only at the final RUN edge (or at reset).
- No combinational path from a, b or start to any output.

Test Plan:
- N=2, reset, then a=3, b=1, start pulse: busy high 2 cycles; done pulses in cycle 3; diff=2, borrow=0; bit_out sequence 0,1.
- N=2, a=1, b=2: diff=3, borrow=1; a=2, b=2: diff=0, borrow=0; results hold in IDLE until the next done.
- N=8, a=0, b=255: diff=1, borrow=1. Change a/b every cycle during RUN; the result must be unchanged.
- N=4, start held high: done pulses every 6 cycles. Operand pairs (9,4), (4,9) give diff=5/borrow=0, then diff=11/borrow=1.
- N=4, start accepted, rst_n pulsed low at RUN cycle 2 (asynchronously, mid-cycle): all outputs 0 immediately, no done. The next operation (7,7) gives diff=0, borrow=0.
- Exhaustive N=3: all 64 (a,b) pairs. diff must equal (a−b)&7 and borrow must equal (a<b), checked at every done pulse.
